keypad_scanner: RTL

Scans a 4x4 hex keypad (Pmod KYPD on a Nexys A7 Pmod header) and returns the pressed key as a 4-bit hex code with a one-cycle valid strobe. It is the input-side counterpart of the seven-segment display path: it drives column strobes and reads rows, where the display path drives anodes and segments. In the top level it runs on the 100 MHz system clock and feeds key values into the counter/SSD datapath, for example as a preload value or a display digit.

---
 rtl/keypad_pkg.sv | 41 ++++
 rtl/keypad_scanner_if.sv | 12 +
 rtl/keypad_sync.sv | 23 ++
 rtl/keypad_scanner.sv | 131 +++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// Combinational helpers only; no latency and no backpressure.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kp_state_t;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Indexed {row, col}; element 0 is the top-left key
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] col_encode(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    function automatic logic single_low(input logic [3:0] rows);
        logic [3:0] low;
        low = ~rows;
        return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the decoded key stream toward the datapath.
// Wires only; the key stream is a strobe with no backpressure.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       valid;
    logic       held;

    modport master (input row, output col, output key, output valid, output held);
    modport slave  (output row, input col, input key, input valid, input held);
endinterface

// File: rtl/keypad_sync.sv
// Generic 2-flop synchronizer with a selectable reset value.
// Latency 2 cycles; no backpressure.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobing, press/release debounce, hex key + 1-cycle valid.
// Valid rises DEBOUNCE_TICKS+1 cycles after the column sample; no backpressure (strobe only).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_TICKS = 2000000
) (
    input  logic             keypad_scanner_clk,
    input  logic             keypad_scanner_rst,
    keypad_scanner_if.master kp
);
    localparam int DW  = $clog2(SCAN_TICKS);
    localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_TICKS - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_TICKS - 1);

    kp_state_t      state_q, state_d;
    logic [1:0]     c_q, c_d;
    logic [3:0]     col_q;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic [DBW-1:0] db_q, db_d;
    logic [3:0]     pat_q, pat_d;
    logic [3:0]     key_q, key_d;
    logic           valid_q, valid_d;
    logic           held_q, held_d;
    logic [3:0]     rs;

    keypad_sync #(.WIDTH(4)) u_sync (
        .clk     (keypad_scanner_clk),
        .rst     (keypad_scanner_rst),
        .rst_val (ROW_IDLE),
        .d       (kp.row),
        .q       (rs)
    );

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        dwell_d = dwell_q;
        db_d    = db_q;
        pat_d   = pat_q;
        key_d   = key_q;
        valid_d = 1'b0;
        held_d  = held_q;
        unique case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (single_low(rs)) begin
                        pat_d   = rs;
                        db_d    = '0;
                        state_d = PRESS_DB;
                    end else begin
                        c_d = c_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            PRESS_DB: begin
                if (rs != pat_q) begin
                    c_d     = c_q + 2'd1;
                    db_d    = '0;
                    dwell_d = '0;
                    state_d = SCAN;
                end else if (db_q == DB_LAST) begin
                    key_d   = KEY_MAP[{row_index(pat_q), c_q}];
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    db_d    = '0;
                    state_d = HELD;
                end else begin
                    db_d = db_q + DBW'(1);
                end
            end
            HELD: begin
                // Extra keys while held are deliberately ignored; only all-idle starts release
                if (rs == ROW_IDLE) begin
                    db_d    = '0;
                    state_d = REL_DB;
                end
            end
            REL_DB: begin
                if (rs != ROW_IDLE) begin
                    db_d    = '0;
                    state_d = HELD;
                end else if (db_q == DB_LAST) begin
                    held_d  = 1'b0;
                    db_d    = '0;
                    dwell_d = '0;
                    c_d     = c_q + 2'd1;
                    state_d = SCAN;
                end else begin
                    db_d = db_q + DBW'(1);
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge keypad_scanner_clk) begin
        if (keypad_scanner_rst) begin
            state_q <= SCAN;
            c_q     <= 2'd0;
            col_q   <= col_encode(2'd0);
            dwell_q <= '0;
            db_q    <= '0;
            pat_q   <= ROW_IDLE;
            key_q   <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            col_q   <= col_encode(c_d);
            dwell_q <= dwell_d;
            db_q    <= db_d;
            pat_q   <= pat_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign kp.col   = col_q;
    assign kp.key   = key_q;
    // Reset must suppress a strobe already sitting in the register
    assign kp.valid = valid_q & ~keypad_scanner_rst;
    assign kp.held  = held_q;
endmodule
